// File: rtl/fifo_push_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// fifo_push_arbiter : round-robin sharing of one Fifo push port, capped per-requester occupancy -- rev 1.0
//-----------------------------------------------------------------------------
module fifo_push_arbiter #(
   parameter  int p_num_reqs     = 4,
   parameter  int p_msg_bits     = 32,
   parameter  int p_max_inflight = 2,
   localparam int p_id_bits      = (p_num_reqs > 2) ? $clog2(p_num_reqs) : 1,
   localparam int p_cnt_bits     = $clog2(p_max_inflight + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [p_num_reqs-1:0]            req_val,
   output logic [p_num_reqs-1:0]            req_rdy,
   input  logic [p_num_reqs*p_msg_bits-1:0] req_msg,
   output logic                             fifo_push,
   output logic [p_msg_bits-1:0]            fifo_wdata,
   output logic [p_id_bits-1:0]             fifo_wid,
   input  logic                             fifo_full,
   input  logic                             fifo_pop,
   input  logic [p_id_bits-1:0]             fifo_rid,
   output logic [p_num_reqs*p_cnt_bits-1:0] inflight,
   output logic                             err
);

   localparam logic [p_cnt_bits-1:0] c_max_cnt  = p_cnt_bits'(p_max_inflight);
   localparam logic [p_id_bits-1:0]  c_last_idx = p_id_bits'(p_num_reqs - 1);

   logic [p_id_bits-1:0]  ptr_q, ptr_d;
   logic [p_cnt_bits-1:0] cnt_q [p_num_reqs];
   logic [p_cnt_bits-1:0] cnt_d [p_num_reqs];
   logic                  err_q, err_d;

   logic                  gnt_vld;
   logic [p_id_bits-1:0]  gnt_idx;
   logic [p_num_reqs-1:0] push_hit;
   logic [p_num_reqs-1:0] pop_ok;
   int                    idx;

   // Scan from the priority pointer; reset and full both suppress any grant.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (rst && !fifo_full) begin
         for (int k = 0; k < p_num_reqs; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= p_num_reqs) idx = idx - p_num_reqs;
            if (!gnt_vld && req_val[idx] && (cnt_q[idx] < c_max_cnt)) begin
               gnt_vld = 1'b1;
               gnt_idx = p_id_bits'(idx);
            end
         end
      end
   end

   always_comb begin
      req_rdy    = '0;
      fifo_wdata = '0;
      for (int i = 0; i < p_num_reqs; i++) begin
         push_hit[i] = gnt_vld && (gnt_idx == p_id_bits'(i));
         req_rdy[i]  = push_hit[i];
         if (push_hit[i]) fifo_wdata = req_msg[i*p_msg_bits +: p_msg_bits];
      end
      fifo_push = gnt_vld;
      fifo_wid  = gnt_idx;
   end

   // A pop to an empty counter is legal only when a push to that index lands in the same cycle.
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < p_num_reqs; i++) begin
         pop_ok[i] = fifo_pop && (fifo_rid == p_id_bits'(i)) &&
                     ((cnt_q[i] != '0) || push_hit[i]);
         cnt_d[i]  = cnt_q[i];
         if (push_hit[i] && !pop_ok[i]) cnt_d[i] = cnt_q[i] + 1'b1;
         else if (pop_ok[i] && !push_hit[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (fifo_pop && (pop_ok == '0)) err_d = 1'b1;
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = (gnt_idx == c_last_idx) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < p_num_reqs; i++) cnt_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         err_q <= err_d;
         for (int i = 0; i < p_num_reqs; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < p_num_reqs; i++) inflight[i*p_cnt_bits +: p_cnt_bits] = cnt_q[i];
      err = err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// tb_fifo_push_arbiter : directed self-checking bench, 4 requesters, cap 2, 8-bit payloads -- rev 1.0
//-----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_val;
   logic [3:0]  req_rdy;
   logic [31:0] req_msg;
   logic        fifo_push;
   logic [7:0]  fifo_wdata;
   logic [1:0]  fifo_wid;
   logic        fifo_full;
   logic        fifo_pop;
   logic [1:0]  fifo_rid;
   logic [7:0]  inflight;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   fifo_push_arbiter #(
      .p_num_reqs     (4),
      .p_msg_bits     (8),
      .p_max_inflight (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_msg    (req_msg),
      .fifo_push  (fifo_push),
      .fifo_wdata (fifo_wdata),
      .fifo_wid   (fifo_wid),
      .fifo_full  (fifo_full),
      .fifo_pop   (fifo_pop),
      .fifo_rid   (fifo_rid),
      .inflight   (inflight),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_val   = '0;
      fifo_pop  = 1'b0;
      fifo_full = 1'b0;
      fifo_rid  = '0;
      step();
      rst = 1'b1;
      #1;
   endtask

   function automatic logic [1:0] inf(input int i);
      return inflight[i*2 +: 2];
   endfunction

   initial begin
      rst = 1'b0; req_val = '0; req_msg = '0;
      fifo_full = 1'b0; fifo_pop = 1'b0; fifo_rid = '0;
      #1;
      req_val = 4'hF;
      #1;
      check("rst_rdy",      32'(req_rdy),   32'h0);
      check("rst_push",     32'(fifo_push), 32'h0);
      check("rst_inflight", 32'(inflight),  32'h0);
      check("rst_err",      32'(err),       32'h0);

      // single requester, then pointer sits at 3
      do_reset();
      req_msg = 32'h00AB_0000;
      req_val = 4'b0100;
      #1;
      check("t1_rdy",   32'(req_rdy),    32'b0100);
      check("t1_push",  32'(fifo_push),  32'h1);
      check("t1_wdata", 32'(fifo_wdata), 32'hAB);
      check("t1_wid",   32'(fifo_wid),   32'h2);
      step();
      req_val = 4'b1001;
      #1;
      check("t1_inf2",   32'(inf(2)),   32'h1);
      check("t1_ptr3",   32'(fifo_wid), 32'h3);
      step();
      req_val = '0;

      // round robin over all four until every slot is capped
      do_reset();
      req_msg = 32'h1312_1110;
      req_val = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t2_wid",   32'(fifo_wid),   32'(k % 4));
         check("t2_wdata", 32'(fifo_wdata), 32'(8'h10 + k % 4));
         check("t2_rdy",   32'(req_rdy),    32'(1 << (k % 4)));
         step();
      end
      check("t2_cap_push", 32'(fifo_push), 32'h0);
      check("t2_cap_rdy",  32'(req_rdy),   32'h0);
      check("t2_inflight", 32'(inflight),  32'hAA);
      req_val = '0;

      // occupancy cap and release by pop
      do_reset();
      req_val = 4'b0010;
      #1;
      check("t3_c1_push", 32'(fifo_push), 32'h1);
      check("t3_c1_wid",  32'(fifo_wid),  32'h1);
      step();
      check("t3_c2_push", 32'(fifo_push), 32'h1);
      step();
      check("t3_c3_rdy",  32'(req_rdy),   32'h0);
      check("t3_c3_inf1", 32'(inf(1)),    32'h2);
      fifo_pop = 1'b1; fifo_rid = 2'd1;
      #1;
      check("t3_c3_rdy_pop", 32'(req_rdy), 32'h0);
      step();
      fifo_pop = 1'b0;
      #1;
      check("t3_c4_inf1", 32'(inf(1)),  32'h1);
      check("t3_c4_rdy",  32'(req_rdy), 32'b0010);
      step();
      req_val = '0;
      #1;
      check("t3_c5_inf1", 32'(inf(1)), 32'h2);

      // full backpressure
      do_reset();
      req_val = 4'b0011; fifo_full = 1'b1;
      #1;
      check("t4_full_push1", 32'(fifo_push), 32'h0);
      check("t4_full_rdy1",  32'(req_rdy),   32'h0);
      step();
      check("t4_full_push2", 32'(fifo_push), 32'h0);
      check("t4_full_inf",   32'(inflight),  32'h0);
      step();
      fifo_full = 1'b0;
      #1;
      check("t4_resume_wid", 32'(fifo_wid), 32'h0);
      check("t4_resume_rdy", 32'(req_rdy),  32'b0001);
      step();
      check("t4_next_wid",   32'(fifo_wid), 32'h1);
      req_val = '0;

      // same-cycle push and pop on index 3, plus pop on index 0 while pushing
      do_reset();
      req_val = 4'b1000;
      step();
      check("t5_inf3_pre", 32'(inf(3)), 32'h1);
      fifo_pop = 1'b1; fifo_rid = 2'd3;
      #1;
      check("t5_rdy", 32'(req_rdy), 32'b1000);
      step();
      fifo_pop = 1'b0; req_val = '0;
      #1;
      check("t5_inf3", 32'(inf(3)), 32'h1);
      check("t5_err",  32'(err),    32'h0);
      req_val = 4'b0001; fifo_pop = 1'b1; fifo_rid = 2'd3;
      step();
      fifo_pop = 1'b0; req_val = '0;
      #1;
      check("t5_indep", 32'(inflight), 32'h01);
      check("t5_err2",  32'(err),      32'h0);

      // illegal pop sets sticky err; async reset clears it without a clock
      do_reset();
      fifo_pop = 1'b1; fifo_rid = 2'd0;
      step();
      fifo_pop = 1'b0;
      #1;
      check("t6_inf0", 32'(inf(0)), 32'h0);
      check("t6_err",  32'(err),    32'h1);
      req_val = 4'b0001;
      step();
      req_val = 4'b1111;
      #1;
      check("t6_err_held", 32'(err),    32'h1);
      check("t6_inf0_up",  32'(inf(0)), 32'h1);
      #1;
      rst = 1'b0;
      #1;
      check("t6_arst_err",  32'(err),       32'h0);
      check("t6_arst_inf",  32'(inflight),  32'h0);
      check("t6_arst_rdy",  32'(req_rdy),   32'h0);
      check("t6_arst_push", 32'(fifo_push), 32'h0);
      step();
      rst = 1'b1; req_val = '0;
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
